// File: rtl/joybus_poll_ctrl.sv
// joybus_poll_ctrl: periodic / on-demand poll sequencer for a Joybus controller.
// Launches command transmission, waits for the reply, latches good reports and
// tracks consecutive failures to decide whether a controller is present.
`timescale 1ns/1ps
module joybus_poll_ctrl #(
    parameter int         POLL_PERIOD = 400000,
    parameter int         RX_TIMEOUT  = 12000,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] POLL_CMD    = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        poll_en,
    input  logic        poll_now,
    output logic        tx_start,
    output logic [7:0]  tx_cmd,
    input  logic        tx_done,
    output logic        rx_start,
    input  logic        rx_done,
    input  logic [31:0] rx_data,
    output logic [31:0] cntlr_state,
    output logic        state_valid,
    output logic        cntlr_present,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [PW-1:0] PERIOD_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RX_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND, ST_WAIT_TX, ST_RECV, ST_WAIT_RX, ST_LATCH, ST_FAIL
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_period_cnt;
    logic          r_pend;
    logic [TW-1:0] r_tmo_cnt;
    logic [RW-1:0] r_retry;
    logic [31:0]   r_rx_buf;
    logic [31:0]   r_cntlr_state;
    logic          r_state_valid;
    logic          r_present;
    logic [7:0]    r_err_cnt;
    logic [7:0]    r_tx_cmd;

    logic          w_period_wrap;
    logic          w_take;
    logic          w_tmo;
    logic          w_rx_good;
    logic [RW-1:0] w_retry_next;
    logic          w_tx_start;
    logic          w_rx_start;
    logic          w_busy;

    assign w_period_wrap = poll_en && (r_period_cnt == PERIOD_LAST);
    assign w_take        = (r_state == ST_IDLE) && r_pend;
    assign w_tmo         = (r_tmo_cnt == TIMEOUT_LAST);
    assign w_rx_good     = (r_rx_buf != 32'hFFFF_FFFF);
    assign w_retry_next  = (r_retry >= (RETRY_MAX - RW'(1))) ? RETRY_MAX : (r_retry + RW'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and strobe outputs; done pulses only count in their wait state.
    always_comb begin
        w_next     = r_state;
        w_tx_start = 1'b0;
        w_rx_start = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (r_pend) w_next = ST_SEND;
            end
            ST_SEND: begin
                w_tx_start = 1'b1;
                w_next     = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done)    w_next = ST_RECV;
                else if (w_tmo) w_next = ST_FAIL;
            end
            ST_RECV: begin
                w_rx_start = 1'b1;
                w_next     = ST_WAIT_RX;
            end
            ST_WAIT_RX: begin
                if (rx_done)    w_next = ST_LATCH;
                else if (w_tmo) w_next = ST_FAIL;
            end
            ST_LATCH: w_next = w_rx_good ? ST_IDLE : ST_FAIL;
            ST_FAIL:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Poll period counter; held at zero while periodic polling is disabled.
    always_ff @(posedge clk) begin
        if (rst || !poll_en)    r_period_cnt <= '0;
        else if (w_period_wrap) r_period_cnt <= '0;
        else                    r_period_cnt <= r_period_cnt + PW'(1);
    end

    // Pending-poll flag; a request arriving in the cycle the flag is consumed merges into that poll.
    always_ff @(posedge clk) begin
        if (rst)                            r_pend <= 1'b0;
        else if (w_take)                    r_pend <= 1'b0;
        else if (w_period_wrap || poll_now) r_pend <= 1'b1;
    end

    // Response timeout counter, restarted whenever a tx or rx phase begins.
    always_ff @(posedge clk) begin
        if (rst)
            r_tmo_cnt <= '0;
        else if (r_state == ST_SEND || r_state == ST_RECV)
            r_tmo_cnt <= '0;
        else if (r_state == ST_WAIT_TX || r_state == ST_WAIT_RX)
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end

    // Capture the receiver shift register on an accepted rx_done.
    always_ff @(posedge clk) begin
        if (r_state == ST_WAIT_RX && rx_done) r_rx_buf <= rx_data;
    end

    // Report latch, presence tracking and error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cntlr_state <= '0;
            r_state_valid <= 1'b0;
            r_present     <= 1'b0;
            r_retry       <= '0;
            r_err_cnt     <= '0;
            r_tx_cmd      <= 8'h00;
        end else begin
            r_state_valid <= 1'b0;
            if (w_take) r_tx_cmd <= POLL_CMD;
            if (r_state == ST_LATCH && w_rx_good) begin
                r_cntlr_state <= r_rx_buf;
                r_state_valid <= 1'b1;
                r_present     <= 1'b1;
                r_retry       <= '0;
            end
            if (r_state == ST_FAIL) begin
                r_err_cnt <= (r_err_cnt == 8'hFF) ? 8'hFF : (r_err_cnt + 8'd1);
                r_retry   <= w_retry_next;
                if (w_retry_next == RETRY_MAX) r_present <= 1'b0;
            end
        end
    end

    assign tx_start      = w_tx_start;
    assign rx_start      = w_rx_start;
    assign busy          = w_busy;
    assign tx_cmd        = r_tx_cmd;
    assign cntlr_state   = r_cntlr_state;
    assign state_valid   = r_state_valid;
    assign cntlr_present = r_present;
    assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_joybus_poll_ctrl.sv
// Bench for joybus_poll_ctrl: acts as transmitter and receiver, predicts each
// poll transaction's timing and outcome from the behavioural rules, and tracks
// the expected controller status in a small transaction-level model.
`timescale 1ns/1ps
module tb_joybus_poll_ctrl;

    localparam int         PP  = 100;
    localparam int         RT  = 20;
    localparam int         MR  = 3;
    localparam logic [7:0] CMD = 8'h5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        poll_en = 1'b0;
    logic        poll_now = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_cmd;
    logic        tx_done = 1'b0;
    logic        rx_start;
    logic        rx_done = 1'b0;
    logic [31:0] rx_data = 32'h0;
    logic [31:0] cntlr_state;
    logic        state_valid;
    logic        cntlr_present;
    logic [7:0]  err_cnt;
    logic        busy;

    joybus_poll_ctrl #(.POLL_PERIOD(PP), .RX_TIMEOUT(RT), .MAX_RETRY(MR), .POLL_CMD(CMD)) dut (
        .clk(clk), .rst(rst), .poll_en(poll_en), .poll_now(poll_now),
        .tx_start(tx_start), .tx_cmd(tx_cmd), .tx_done(tx_done),
        .rx_start(rx_start), .rx_done(rx_done), .rx_data(rx_data),
        .cntlr_state(cntlr_state), .state_valid(state_valid),
        .cntlr_present(cntlr_present), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          m_err = 0;
    int          m_retry = 0;
    bit          m_present = 0;
    logic [31:0] m_state = 32'h0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Advance to the next cycle's sampling point and clear all pulse inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        poll_now = 1'b0;
        tx_done  = 1'b0;
        rx_done  = 1'b0;
        rst      = 1'b0;
        rx_data  = $urandom;
    endtask

    // Cycle (relative to tx_start) at which the DUT is back in idle with results visible.
    function automatic int exp_end(input int dtx, input int drx, input logic [31:0] data);
        int r;
        r = dtx + 1;
        if (dtx < 1 || dtx > RT)        return RT + 2;
        if (drx < 1 || drx > RT)        return r + RT + 2;
        if (data != 32'hFFFF_FFFF)      return r + drx + 2;
        return r + drx + 3;
    endfunction

    // One poll: tx_done dtx cycles after tx_start, rx_done drx cycles after rx_start.
    task automatic run_txn(input int max_wait, input int dtx, input int drx, input logic [31:0] data,
                           input int pn1, input int pn2, output int t_start, output int t_end);
        int w;
        int r;
        int e;
        bit acc_tx;
        bit acc_rx;
        bit good;
        logic [3:0] ev;
        w = 0;
        while (tx_start !== 1'b1 && w < max_wait) begin
            tick();
            w++;
        end
        check_eq("tx_start_seen", 64'(tx_start), 64'(1));
        t_start = cyc;
        t_end   = cyc;
        if (tx_start !== 1'b1) return;
        acc_tx = (dtx >= 1 && dtx <= RT);
        acc_rx = acc_tx && (drx >= 1 && drx <= RT);
        good   = acc_rx && (data != 32'hFFFF_FFFF);
        r      = dtx + 1;
        e      = exp_end(dtx, drx, data);
        for (int k = 0; k <= e; k++) begin
            if (k > 0) tick();
            ev[3] = (k == 0);
            ev[2] = acc_tx && (k == r);
            ev[1] = good && (k == e);
            ev[0] = (k < e);
            check_eq("strobes{tx,rx,valid,busy}", 64'({tx_start, rx_start, state_valid, busy}), 64'(ev));
            if (k == 0) check_eq("tx_cmd", 64'(tx_cmd), 64'(CMD));
            if (k == e) begin
                if (good) begin
                    m_state   = data;
                    m_present = 1;
                    m_retry   = 0;
                end else begin
                    m_err   = (m_err < 255) ? m_err + 1 : 255;
                    m_retry = (m_retry < MR) ? m_retry + 1 : MR;
                    if (m_retry == MR) m_present = 0;
                end
                check_eq("err_cnt", 64'(err_cnt), 64'(m_err));
                check_eq("cntlr_present", 64'(cntlr_present), 64'(m_present));
                check_eq("cntlr_state", 64'(cntlr_state), 64'(m_state));
            end
            if (k == dtx) tx_done = 1'b1;
            if (acc_tx && k == r + drx) begin
                rx_done = 1'b1;
                rx_data = data;
            end
            if (k < e && (k == pn1 || k == pn2)) poll_now = 1'b1;
        end
        t_end = cyc;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("idle{tx,rx,busy}", 64'({tx_start, rx_start, busy}), 64'(0));
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got no finish, want finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int ts;
        int te;
        int ts2;
        int te2;
        int prev_start;
        int dtx;
        int drx;
        int pn1;
        int pn2;
        int e;
        int lat;
        bit pend;
        logic [31:0] data;

        // Reset state
        repeat (3) begin
            rst = 1'b1;
            tick();
        end
        check_eq("rst_strobes", 64'({tx_start, rx_start, state_valid, busy, cntlr_present}), 64'(0));
        check_eq("rst_err_cnt", 64'(err_cnt), 64'(0));
        check_eq("rst_cntlr_state", 64'(cntlr_state), 64'(0));
        check_eq("rst_tx_cmd", 64'(tx_cmd), 64'(0));
        idle_check(3);

        // Periodic polling with a well-behaved controller
        poll_en = 1'b1;
        c0 = cyc;
        run_txn(PP + 20, 3, 5, 32'h1234_5678, -1, -1, ts, te);
        check_eq("period_first", 64'(ts - c0), 64'(PP + 1));
        prev_start = ts;
        for (int i = 0; i < 2; i++) begin
            run_txn(PP + 20, 3, 5, 32'h1234_5678, -1, -1, ts, te);
            check_eq("period_interval", 64'(ts - prev_start), 64'(PP));
            prev_start = ts;
        end
        poll_en = 1'b0;
        check_eq("periodic_state", 64'(cntlr_state), 64'(32'h1234_5678));
        idle_check(4);

        // Three consecutive receive timeouts
        for (int i = 0; i < 3; i++) begin
            tick();
            poll_now = 1'b1;
            run_txn(5, 2, RT + 1, 32'h0, -1, -1, ts, te);
        end
        check_eq("err_after_3_timeouts", 64'(err_cnt), 64'(3));
        check_eq("absent_after_3_timeouts", 64'(cntlr_present), 64'(0));

        // Good report then an all-ones report
        tick();
        poll_now = 1'b1;
        run_txn(5, 4, 7, 32'hCAFE_F00D, -1, -1, ts, te);
        tick();
        poll_now = 1'b1;
        run_txn(5, 1, 2, 32'hFFFF_FFFF, -1, -1, ts, te);
        check_eq("ones_keeps_state", 64'(cntlr_state), 64'(32'hCAFE_F00D));
        check_eq("ones_err_inc", 64'(err_cnt), 64'(4));

        // Two poll_now pulses during the receive wait collapse into one extra poll
        tick();
        poll_now = 1'b1;
        run_txn(5, 2, 12, 32'h0BAD_BEEF, 5, 9, ts, te);
        run_txn(3, 2, 4, 32'h0000_1111, -1, -1, ts2, te2);
        check_eq("merged_latency_ok", 64'((ts2 - te) >= 1 && (ts2 - te) <= 2), 64'(1));
        idle_check(8);

        // Randomized transactions
        pend = 0;
        te = cyc;
        for (int i = 0; i < 40; i++) begin
            if (!pend) begin
                tick();
                poll_now = 1'b1;
                c0 = cyc;
            end
            dtx  = ($urandom_range(0, 7) == 0) ? RT + 1 + $urandom_range(0, 1) : $urandom_range(1, RT);
            drx  = ($urandom_range(0, 7) == 0) ? RT + 1 + $urandom_range(0, 1) : $urandom_range(1, RT);
            data = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            e    = exp_end(dtx, drx, data);
            pn1  = -1;
            pn2  = -1;
            if (i < 39) begin
                if ($urandom_range(0, 2) != 0) pn1 = $urandom_range(0, e - 1);
                if ($urandom_range(0, 2) == 0) pn2 = $urandom_range(0, e - 1);
            end
            if (pend) begin
                prev_start = te;
                run_txn(4, dtx, drx, data, pn1, pn2, ts, te);
                lat = ts - prev_start;
                check_eq("chained_latency_ok", 64'(lat >= 1 && lat <= 2), 64'(1));
            end else begin
                run_txn(5, dtx, drx, data, pn1, pn2, ts, te);
                lat = ts - c0;
                check_eq("poll_now_latency_ok", 64'(lat >= 1 && lat <= 3), 64'(1));
            end
            pend = (pn1 >= 0 || pn2 >= 0);
        end
        idle_check(5);

        // Reset in the middle of the transmit wait; the late tx_done must be ignored
        tick();
        poll_now = 1'b1;
        c0 = 0;
        while (tx_start !== 1'b1 && c0 < 5) begin
            tick();
            c0++;
        end
        check_eq("rst_txn_start", 64'(tx_start), 64'(1));
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("midrst_strobes", 64'({tx_start, rx_start, state_valid, busy, cntlr_present}), 64'(0));
        check_eq("midrst_err_cnt", 64'(err_cnt), 64'(0));
        check_eq("midrst_cntlr_state", 64'(cntlr_state), 64'(0));
        check_eq("midrst_tx_cmd", 64'(tx_cmd), 64'(0));
        tx_done = 1'b1;
        idle_check(6);
        m_err     = 0;
        m_retry   = 0;
        m_present = 0;
        m_state   = 32'h0;

        // Drive err_cnt into saturation
        for (int i = 0; i < 257; i++) begin
            tick();
            poll_now = 1'b1;
            run_txn(5, 1, 1, 32'hFFFF_FFFF, -1, -1, ts, te);
        end
        check_eq("err_cnt_saturated", 64'(err_cnt), 64'(8'hFF));
        check_eq("sat_state_unchanged", 64'(cntlr_state), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/joybus_poll_ctrl.md
JOYBUS_POLL_CTRL -- requirements
Module: joybus_poll_ctrl

Interface
REQ-001 SHALL have parameter POLL_PERIOD, default 400000, meaning clk cycles between poll starts (16 ms at 25 MHz).
REQ-002 SHALL have parameter RX_TIMEOUT, default 12000, meaning clk cycles allowed from rx_start to rx_done.
REQ-003 SHALL have parameter MAX_RETRY, default 3, meaning consecutive failed polls before cntlr_present deasserts.
REQ-004 SHALL have parameter POLL_CMD, default 8'h01, meaning command byte sent on each poll.
REQ-005 Ports (name  dir  width  meaning): clk  in  1  the single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 poll_en  in  1  enables periodic polling.
REQ-008 poll_now  in  1  single-cycle pulse requesting an immediate poll.
REQ-009 tx_start  out  1  single-cycle pulse to the transmitter.
REQ-010 tx_cmd  out  8  command byte, held stable from tx_start until tx_done.
REQ-011 tx_done  in  1  single-cycle pulse; transmitter finished, including stop bit.
REQ-012 rx_start  out  1  single-cycle pulse to the receiver.
REQ-013 rx_done  in  1  single-cycle pulse; receiver finished.
REQ-014 rx_data  in  32  receiver shift-register contents, valid in the rx_done cycle.
REQ-015 cntlr_state  out  32  last good controller report.
REQ-016 state_valid  out  1  single-cycle pulse when cntlr_state updates.
REQ-017 cntlr_present  out  1  controller is responding.
REQ-018 err_cnt  out  8  saturating count of failed polls.
REQ-019 busy  out  1  poll transaction in progress.

Function
REQ-020 FSM states SHALL be IDLE, SEND, WAIT_TX, RECV, WAIT_RX, LATCH, FAIL.
REQ-021 Period counter SHALL count while poll_en=1 and clear when poll_en=0; at POLL_PERIOD-1 it SHALL wrap to 0 and raise a pending-poll flag.
REQ-022 poll_now SHALL set the pending-poll flag regardless of poll_en; further requests while the flag is set SHALL merge into it.
REQ-023 IDLE: when the pending-poll flag is set, the FSM SHALL clear the flag and go to SEND the next cycle.
REQ-024 SEND: the FSM SHALL assert tx_start for exactly one cycle, drive tx_cmd=POLL_CMD, and go to WAIT_TX.
REQ-025 WAIT_TX: on tx_done, the FSM SHALL go to RECV; if tx_done is absent for RX_TIMEOUT cycles, it SHALL go to FAIL.
REQ-026 RECV: the FSM SHALL assert rx_start for exactly one cycle, clear the timeout counter, and go to WAIT_RX.
REQ-027 WAIT_RX: on rx_done, the FSM SHALL capture rx_data and go to LATCH; at a timeout count of RX_TIMEOUT-1 with no rx_done, it SHALL go to FAIL.
REQ-028 LATCH: if captured data != 32'hFFFFFFFF, the block SHALL load cntlr_state, pulse state_valid, set cntlr_present=1, and clear the retry count; otherwise it SHALL go to FAIL; on success the next state SHALL be IDLE.
REQ-029 FAIL: the block SHALL increment err_cnt (saturating at 8'hFF) and the retry count; when the retry count reaches MAX_RETRY, it SHALL set cntlr_present=0 and hold the retry count at MAX_RETRY; the next state SHALL be IDLE; cntlr_state SHALL remain unchanged.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 Pending-poll events occurring while busy=1 SHALL set the flag and be served on return to IDLE, never lost, never double-counted.
REQ-032 tx_done or rx_done outside WAIT_TX or WAIT_RX respectively SHALL be ignored.
REQ-033 Worst-case latency from the pending-poll flag being set to tx_start SHALL be 2 cycles when the FSM is in IDLE.
REQ-034 tx_start and rx_start SHALL never be asserted in the same cycle.

Reset
REQ-035 When rst=1, the block SHALL enter IDLE on the next clock edge, including in the middle of a transaction.
REQ-036 In that same edge, the block SHALL clear: period counter, timeout counter, retry count, pending-poll flag, tx_start, rx_start, state_valid, busy, err_cnt, cntlr_present, cntlr_state; tx_cmd SHALL reset to 8'h00.

Verification
REQ-037 POLL_PERIOD=100, poll_en=1, transmitter/receiver model returns rx_data=32'h12345678 -> tx_start every 100 cycles, cntlr_state=32'h12345678, state_valid pulses once per poll, cntlr_present=1.
REQ-038 Receiver model never pulses rx_done, MAX_RETRY=3 -> three FAIL visits, each WAIT_RX exit exactly RX_TIMEOUT cycles after rx_start, err_cnt=3, cntlr_present=0 after the third failure.
REQ-039 rx_data=32'hFFFFFFFF after one good poll -> cntlr_state keeps its prior value, err_cnt increments by 1, no state_valid pulse.
REQ-040 poll_now pulsed twice during WAIT_RX -> exactly one additional poll after return to IDLE.
REQ-041 rst asserted for 1 cycle during WAIT_TX -> IDLE next cycle, all outputs at reset values, a late tx_done is ignored.
REQ-042 err_cnt preloaded to 8'hFE via repeated failures, then 3 more failures -> err_cnt holds 8'hFF.
